fetch_pc_sequencer: RTL and testbench
=====================================

// Module: fetch_pc_sequencer
// PURPOSE
//  Next-PC controller for the fetch stage. Each cycle selects the PC the fetch unit
//  reads from instruction memory, choosing between reset vector, execute-stage
//  redirect, stall hold, predicted-taken branch target and sequential PC+1.
//  Holds a 2-bit saturating branch history table (BHT) that is trained by execute,
//  and raises a flush to the front end on a misprediction. Word-addressed PC.
// PARAMETERS
//  PC_W      32   PC / target width in bits
//  BHT_IDX   4    BHT index bits; table depth = 2**BHT_IDX, indexed by pc[BHT_IDX-1:0]
//  RESET_PC  0    PC value loaded on reset
//  CNT_W     16   width of the mispredict event counter
// PORTS
//  clk            in   1        clock, all state updates on posedge
//  rst            in   1        synchronous active-high reset
//  stall          in   1        hold PC (downstream not accepting a new fetch)
//  if_is_br       in   1        word at current pc is a conditional branch
//  if_target      in   PC_W     branch target decoded from word at current pc
//  ex_valid       in   1        execute stage has a resolved instruction this cycle
//  ex_is_br       in   1        resolved instruction is a conditional branch
//  ex_taken       in   1        actual branch outcome
//  ex_pred_taken  in   1        prediction that travelled down the pipe with it
//  ex_pc          in   PC_W     PC of the resolved branch
//  ex_target      in   PC_W     actual taken target of the resolved branch
//  pc             out  PC_W     current fetch PC (registered)
//  pred_taken     out  1        prediction for word at pc (combinational)
//  flush          out  1        kill younger in-flight instructions (combinational)
//  mispred_cnt    out  CNT_W    number of mispredictions, saturating (registered)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, every BHT entry=2'b01 (weakly not taken), mispred_cnt=0.
//    rst overrides all other inputs in the same cycle, including a pending redirect.
//  - Resolve: res = ex_valid & ex_is_br. mispredict = res & (ex_taken != ex_pred_taken).
//  - flush = mispredict (same cycle, not gated by stall).
//  - pred_taken = if_is_br & bht[pc[BHT_IDX-1:0]][1]; 0 when if_is_br=0.
//  - Next pc on posedge, priority high to low:
//      1 rst         -> RESET_PC
//      2 mispredict  -> ex_taken ? ex_target : ex_pc+1
//      3 stall       -> pc (hold)
//      4 pred_taken  -> if_target
//      5 otherwise   -> pc+1
//    Redirect wins over stall. Additions are modulo 2**PC_W (all-ones+1 -> 0).
//  - BHT training: when res, entry ex_pc[BHT_IDX-1:0] increments if ex_taken
//    (saturate at 3) else decrements (saturate at 0). Training occurs on every
//    resolved branch regardless of stall or mispredict.
//  - Same-index lookup and update in one cycle: pred_taken uses the pre-update value;
//    new value visible from next cycle.
//  - mispred_cnt increments by 1 per mispredict cycle; holds at 2**CNT_W-1.
//  - ex_* inputs ignored when ex_valid=0; if_* ignored when if_is_br=0.
//  - Single-cycle latency: a redirect presented in cycle N appears on pc in N+1.
// TESTING
//  1 Reset: assert rst 2 cycles mid-run at pc=0x7 -> pc=0x0, mispred_cnt=0,
//    pred_taken=0 with if_is_br=1 at any index.
//  2 Sequential/stall: no branches, stall high cycles 3-4 -> pc 0,1,2,3,3,3,4;
//    pc=0xFFFFFFFF with no stall -> next pc=0x0.
//  3 Training: resolve taken branch at ex_pc=0x5 twice -> entry 5 goes 01->10->11;
//    then if_is_br=1 at pc=0x5, if_target=0xC -> pred_taken=1, next pc=0xC.
//  4 Mispredict not-taken: ex_pred_taken=1, ex_taken=0, ex_pc=0x4 with stall=1
//    -> flush=1 that cycle, next pc=0x5, mispred_cnt+1.
//  5 Mispredict taken + same-index lookup: pc=0x2 if_is_br=1, entry=01, execute
//    resolves ex_pc=0x2 taken, pred 0, target 0x9 -> pred_taken=0, flush=1,
//    next pc=0x9, entry 2=10; rst same cycle instead -> pc=RESET_PC.
//  6 Counter saturation (CNT_W=4): 17 mispredicts -> mispred_cnt stops at 0xF.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage next-PC selection with a 2-bit saturating branch history table.
// Execute-stage redirects take priority over stall, and every mispredict raises a flush.
module fetch_pc_sequencer #(
   parameter int              PC_W     = 32,
   parameter int              BHT_IDX  = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             if_is_br,
   input  logic [PC_W-1:0]  if_target,
   input  logic             ex_valid,
   input  logic             ex_is_br,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic [PC_W-1:0]  ex_target,
   output logic [PC_W-1:0]  pc,
   output logic             pred_taken,
   output logic             flush,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int DEPTH = 1 << BHT_IDX;

   logic [1:0]         bht [DEPTH];
   logic               res;
   logic               mispredict;
   logic [BHT_IDX-1:0] if_idx;
   logic [BHT_IDX-1:0] ex_idx;
   logic [PC_W-1:0]    pc_next;

   assign if_idx = pc[BHT_IDX-1:0];
   assign ex_idx = ex_pc[BHT_IDX-1:0];

   // Lookup reads the table before this cycle's training write lands.
   always_comb begin
      res        = ex_valid & ex_is_br;
      mispredict = res & (ex_taken != ex_pred_taken);
      flush      = mispredict;
      pred_taken = if_is_br & bht[if_idx][1];
      pc_next    = pc + PC_W'(1);
      if (mispredict) begin
         pc_next = ex_taken ? ex_target : ex_pc + PC_W'(1);
      end else if (stall) begin
         pc_next = pc;
      end else if (pred_taken) begin
         pc_next = if_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         mispred_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            bht[i] <= 2'b01;
         end
      end else begin
         pc <= pc_next;
         if (mispredict && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
         if (res) begin
            if (ex_taken && (bht[ex_idx] != 2'b11)) begin
               bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else if (!ex_taken && (bht[ex_idx] != 2'b00)) begin
               bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed and randomized bench for fetch_pc_sequencer, checked against a
// behavioural next-PC / prediction-table model. CNT_W is 4 so counter saturation is reachable.
module tb_fetch_pc_sequencer;

   localparam int PC_W    = 32;
   localparam int BHT_IDX = 4;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             if_is_br;
   logic [PC_W-1:0]  if_target;
   logic             ex_valid;
   logic             ex_is_br;
   logic             ex_taken;
   logic             ex_pred_taken;
   logic [PC_W-1:0]  ex_pc;
   logic [PC_W-1:0]  ex_target;
   logic [PC_W-1:0]  pc;
   logic             pred_taken;
   logic             flush;
   logic [CNT_W-1:0] mispred_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_pc;
   int          m_bht [16];
   int          m_cnt;

   always #5 clk = ~clk;

   fetch_pc_sequencer #(
      .PC_W(PC_W), .BHT_IDX(BHT_IDX), .RESET_PC(32'h0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .if_is_br(if_is_br), .if_target(if_target),
      .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_taken(ex_taken),
      .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .pc(pc), .pred_taken(pred_taken), .flush(flush), .mispred_cnt(mispred_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 0; stall = 0; if_is_br = 0; if_target = '0;
      ex_valid = 0; ex_is_br = 0; ex_taken = 0; ex_pred_taken = 0;
      ex_pc = '0; ex_target = '0;
   endtask

   task automatic resolve(input logic taken, input logic pred, input logic [31:0] bpc,
                          input logic [31:0] tgt);
      ex_valid = 1; ex_is_br = 1; ex_taken = taken; ex_pred_taken = pred;
      ex_pc = bpc; ex_target = tgt;
   endtask

   // Check combinational outputs mid-cycle, advance the model, then check registered outputs.
   task automatic step(input string tag);
      bit res, mis, exp_pred;
      int idx;
      #1;
      res      = ex_valid && ex_is_br;
      mis      = res && (ex_taken != ex_pred_taken);
      exp_pred = if_is_br && (m_bht[m_pc[3:0]] >= 2);
      check({tag, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, exp_pred});
      check({tag, ".flush"}, {31'b0, flush}, {31'b0, mis});
      if (rst) begin
         m_pc  = 32'h0;
         m_cnt = 0;
         for (int i = 0; i < 16; i++) m_bht[i] = 1;
      end else begin
         if (mis)           m_pc = ex_taken ? ex_target : ex_pc + 32'd1;
         else if (stall)    m_pc = m_pc;
         else if (exp_pred) m_pc = if_target;
         else               m_pc = m_pc + 32'd1;
         if (res) begin
            idx = int'(ex_pc[3:0]);
            if (ex_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else          m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
         end
         if (mis && m_cnt < 15) m_cnt++;
      end
      @(posedge clk);
      #1;
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".mispred_cnt"}, {28'b0, mispred_cnt}, m_cnt);
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      m_pc = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      check("reset.pc", pc, 32'h0);
      check("reset.cnt", {28'b0, mispred_cnt}, 32'h0);

      // Reset mid-run at pc 7, after entry 0 has been trained strongly taken.
      for (int i = 0; i < 7; i++) begin
         idle();
         if (i < 2) resolve(1, 1, 32'h10, 32'h0);
         step("t1.run");
      end
      check("t1.pc_before", pc, 32'h7);
      for (int i = 0; i < 2; i++) begin
         idle(); rst = 1; if_is_br = 1; if_target = 32'h33;
         resolve(1, 0, 32'h3, 32'h44);
         step("t1.rst");
      end
      check("t1.pc_after", pc, 32'h0);
      idle(); if_is_br = 1; if_target = 32'h33;
      step("t1.pred_idx0");

      // Sequential with two stall cycles, then wrap from all-ones.
      idle(); rst = 1; step("t2.rst");
      for (int i = 0; i < 6; i++) begin
         idle();
         stall = (i == 3 || i == 4);
         step("t2.seq");
      end
      check("t2.pc_seq", pc, 32'h4);
      idle(); resolve(1, 0, 32'h8, 32'hFFFF_FFFF); step("t2.to_max");
      check("t2.pc_max", pc, 32'hFFFF_FFFF);
      idle(); step("t2.wrap");
      check("t2.pc_wrap", pc, 32'h0);

      // Train entry 5 twice, then predict taken at pc 5.
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i < 2) resolve(1, 1, 32'h5, 32'h20);
         step("t3.train");
      end
      idle(); if_is_br = 1; if_target = 32'hC;
      #1;
      check("t3.pred_const", {31'b0, pred_taken}, 32'h1);
      step("t3.predict");
      check("t3.pc_target", pc, 32'hC);

      // Not-taken mispredict while stalled still redirects.
      idle(); stall = 1; resolve(0, 1, 32'h4, 32'h99);
      #1;
      check("t4.flush_const", {31'b0, flush}, 32'h1);
      step("t4.mispred");
      check("t4.pc", pc, 32'h5);

      // Taken mispredict with same-index lookup, then the same with reset.
      idle(); resolve(0, 1, 32'h1, 32'h0); step("t5.to2");
      idle(); if_is_br = 1; if_target = 32'h3; resolve(1, 0, 32'h2, 32'h9);
      step("t5.same_idx");
      check("t5.pc", pc, 32'h9);
      idle(); resolve(0, 1, 32'h1, 32'h0); step("t5.to2b");
      idle(); rst = 1; if_is_br = 1; if_target = 32'h3; resolve(1, 0, 32'h2, 32'h9);
      step("t5.rst_wins");
      check("t5.pc_rst", pc, 32'h0);

      // Seventeen consecutive mispredicts saturate the counter.
      for (int i = 0; i < 17; i++) begin
         idle(); resolve(i[0], ~i[0], 32'(i), 32'h100 + 32'(i));
         step("t6.sat");
      end
      check("t6.cnt_sat", {28'b0, mispred_cnt}, 32'hF);

      // Randomized traffic.
      idle(); rst = 1; step("rnd.rst");
      for (int i = 0; i < 400; i++) begin
         rst           = ($urandom_range(0, 39) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         if_is_br      = $urandom_range(0, 1);
         if_target     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
         ex_valid      = ($urandom_range(0, 2) != 0);
         ex_is_br      = ($urandom_range(0, 2) != 0);
         ex_taken      = $urandom_range(0, 1);
         ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
         ex_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 31));
         ex_target     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
